fp_unit_arbiter: RTL

//  Responder side of the fp valid/ready/finish handshake used by the CMU_* blocks.

---
 rtl/fp_arb_pkg.sv | 13 +
 rtl/fp_arb_tag_fifo.sv | 60 ++++++
 rtl/fp_unit_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp unit arbiter.
package fp_arb_pkg;

    localparam int unsigned FP_DBL_WIDTH    = 64;
    localparam int unsigned FP_NUM_CLIENTS  = 4;
    localparam int unsigned FP_MAX_INFLIGHT = 4;

    // Idle cycles forced after each issue so a late-dropping u_ready is honoured.
    localparam int unsigned FP_ISSUE_GAP = 1;

    typedef logic [$clog2(FP_NUM_CLIENTS)-1:0] client_id_t;

endpackage

// File: rtl/fp_arb_tag_fifo.sv
// Owner-tag FIFO: records which client each in-flight fp op belongs to, in issue order.
module fp_arb_tag_fifo
    import fp_arb_pkg::*;
#(
    parameter int unsigned DEPTH = FP_MAX_INFLIGHT,
    parameter int unsigned WIDTH = $bits(client_id_t)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Tag storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one fp multiplier/adder between several CMU client ports using
// round-robin issue and an owner-tag FIFO to route results back.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned DBL_WIDTH    = FP_DBL_WIDTH,
    parameter int unsigned NUM_CLIENTS  = FP_NUM_CLIENTS,
    parameter int unsigned MAX_INFLIGHT = FP_MAX_INFLIGHT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CLIENTS-1:0]               c_valid,
    input  logic [NUM_CLIENTS-1:0][DBL_WIDTH-1:0] c_a,
    input  logic [NUM_CLIENTS-1:0][DBL_WIDTH-1:0] c_b,
    output logic [NUM_CLIENTS-1:0]               c_ready,
    output logic [NUM_CLIENTS-1:0]               c_finish,
    output logic [DBL_WIDTH-1:0]                 c_result,
    output logic                                 u_valid,
    output logic [DBL_WIDTH-1:0]                 u_a,
    output logic [DBL_WIDTH-1:0]                 u_b,
    input  logic                                 u_ready,
    input  logic                                 u_finish,
    input  logic [DBL_WIDTH-1:0]                 u_result,
    output logic                                 err_proto
);

    localparam int unsigned TAG_W = $clog2(NUM_CLIENTS);
    localparam int unsigned GAP_W = $clog2(FP_ISSUE_GAP + 1);

    logic [NUM_CLIENTS-1:0]                pending;
    logic [NUM_CLIENTS-1:0]                busy;
    logic [NUM_CLIENTS-1:0][DBL_WIDTH-1:0] op_a;
    logic [NUM_CLIENTS-1:0][DBL_WIDTH-1:0] op_b;
    logic [TAG_W-1:0]                      rr_ptr;
    logic [TAG_W-1:0]                      grant_id;
    logic [TAG_W-1:0]                      pop_id;
    logic [GAP_W-1:0]                      gap_cnt;
    logic                                  issue;
    logic                                  pop;
    logic                                  fifo_full;
    logic                                  fifo_empty;

    // First requester at or after ptr. Scanning backwards lets the nearest one win last.
    function automatic logic [TAG_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                 input logic [TAG_W-1:0]       ptr);
        logic [TAG_W-1:0] pick;
        logic [TAG_W-1:0] idx;
        pick = '0;
        for (int unsigned k = NUM_CLIENTS; k > 0; k--) begin
            idx = TAG_W'((32'(ptr) + k - 1) % NUM_CLIENTS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    assign grant_id = rr_pick(pending, rr_ptr);
    assign issue    = u_ready && (|pending) && !fifo_full && (gap_cnt == '0);
    assign pop      = u_finish && !fifo_empty;
    assign c_ready  = ~busy;

    fp_arb_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (issue),
        .push_data (grant_id),
        .pop       (pop),
        .pop_data  (pop_id),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Client slots: accept a request when idle, drop pending on grant, free on result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            busy    <= '0;
            op_a    <= '0;
            op_b    <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
                if (c_valid[i] && !busy[i]) begin
                    op_a[i]    <= c_a[i];
                    op_b[i]    <= c_b[i];
                    pending[i] <= 1'b1;
                    busy[i]    <= 1'b1;
                end else if (issue && (grant_id == TAG_W'(i))) begin
                    pending[i] <= 1'b0;
                end
                if (pop && (pop_id == TAG_W'(i))) busy[i] <= 1'b0;
            end
        end
    end

    // Issue register: one-cycle u_valid pulse, operands held, pointer advanced past the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_valid <= 1'b0;
            u_a     <= '0;
            u_b     <= '0;
            rr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            u_valid <= issue;
            if (issue) begin
                u_a     <= op_a[grant_id];
                u_b     <= op_b[grant_id];
                rr_ptr  <= (grant_id == TAG_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
                gap_cnt <= GAP_W'(FP_ISSUE_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    // Return path and sticky protocol error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_finish  <= '0;
            c_result  <= '0;
            err_proto <= 1'b0;
        end else begin
            c_finish <= '0;
            if (pop) begin
                c_finish[pop_id] <= 1'b1;
                c_result         <= u_result;
            end
            err_proto <= err_proto | (|(c_valid & busy)) | (u_finish & fifo_empty);
        end
    end

endmodule
